// File: rtl/rect_raster_renderer.sv
// Raster-order renderer feeding the back buffer: one pixel per cycle, a solid
// rectangle over a flat background, bouncing one step per completed frame.
module rect_raster_renderer #(
    parameter int         FB_W     = 160,
    parameter int         FB_H     = 120,
    parameter int         RECT_W   = 20,
    parameter int         RECT_H   = 16,
    parameter logic [8:0] BG_COLOR = 9'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [9:0]  SW,
    output logic        loaded,
    output logic [8:0]  dataIn,
    output logic [31:0] drawIndex,
    output logic        drawEn
);
    localparam int XW = $clog2(FB_W) + 1;
    localparam int YW = $clog2(FB_H) + 1;
    localparam logic [XW-1:0] X_MAX  = XW'(FB_W - 1);
    localparam logic [XW-1:0] X_SPAN = XW'(FB_W);
    localparam logic [XW-1:0] X_RECT = XW'(RECT_W);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_MAX  = YW'(FB_H - 1);
    localparam logic [YW-1:0] Y_SPAN = YW'(FB_H);
    localparam logic [YW-1:0] Y_RECT = YW'(RECT_H);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE, WAIT_ACK} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   cx_q, cx_d, px_q, px_d;
    logic [YW-1:0]   cy_q, cy_d, py_q, py_d;
    logic            dxn_q, dxn_d, dyn_q, dyn_d;   // 1 = moving in the negative direction
    logic            loaded_q, loaded_d, draw_en_q, draw_en_d;
    logic [8:0]      data_q, data_d;
    logic [31:0]     index_q, index_d;
    logic            in_rect;

    assign in_rect = (cx_q >= px_q) && (cx_q < px_q + X_RECT) &&
                     (cy_q >= py_q) && (cy_q < py_q + Y_RECT);

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        px_d      = px_q;
        py_d      = py_q;
        dxn_d     = dxn_q;
        dyn_d     = dyn_q;
        loaded_d  = 1'b0;
        draw_en_d = 1'b0;
        data_d    = data_q;
        index_d   = index_q;
        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = DRAW;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            DRAW: begin
                if (ready) begin
                    draw_en_d = 1'b1;
                    index_d   = 32'(cy_q) * 32'(FB_W) + 32'(cx_q);
                    data_d    = in_rect ? SW[8:0] : BG_COLOR;
                    if (cx_q == X_MAX) begin
                        cx_d = '0;
                        if (cy_q == Y_MAX) state_d = DONE;
                        else               cy_d    = cy_q + Y_ONE;
                    end else begin
                        cx_d = cx_q + X_ONE;
                    end
                end
            end
            DONE: begin
                loaded_d = 1'b1;
                state_d  = WAIT_ACK;
                if (!SW[9]) begin
                    // Bounce takes effect in the same step: the edge is never overshot.
                    if (RECT_W == FB_W)                       px_d = '0;
                    else if (!dxn_q && (px_q + X_RECT == X_SPAN)) begin
                        dxn_d = 1'b1;
                        px_d  = px_q - X_ONE;
                    end else if (dxn_q && (px_q == '0)) begin
                        dxn_d = 1'b0;
                        px_d  = px_q + X_ONE;
                    end else begin
                        px_d  = dxn_q ? px_q - X_ONE : px_q + X_ONE;
                    end

                    if (RECT_H == FB_H)                       py_d = '0;
                    else if (!dyn_q && (py_q + Y_RECT == Y_SPAN)) begin
                        dyn_d = 1'b1;
                        py_d  = py_q - Y_ONE;
                    end else if (dyn_q && (py_q == '0)) begin
                        dyn_d = 1'b0;
                        py_d  = py_q + Y_ONE;
                    end else begin
                        py_d  = dyn_q ? py_q - Y_ONE : py_q + Y_ONE;
                    end
                end
            end
            WAIT_ACK: begin
                if (!ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            dxn_q     <= 1'b0;
            dyn_q     <= 1'b0;
            loaded_q  <= 1'b0;
            draw_en_q <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            px_q      <= px_d;
            py_q      <= py_d;
            dxn_q     <= dxn_d;
            dyn_q     <= dyn_d;
            loaded_q  <= loaded_d;
            draw_en_q <= draw_en_d;
            data_q    <= data_d;
            index_q   <= index_d;
        end
    end

    assign loaded    = loaded_q;
    assign drawEn    = draw_en_q;
    assign dataIn    = data_q;
    assign drawIndex = index_q;
endmodule

// File: tb/tb_rect_raster_renderer.sv
// Directed bench for rect_raster_renderer on an 8x4 buffer with a 2x2 rectangle;
// expected pixels are queued per frame from a position model and popped on drawEn.
module tb_rect_raster_renderer;
    localparam int W = 8, H = 4, RW = 2, RH = 2, N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready = 1'b0;
    logic [9:0]  SW = '0;
    logic        loaded;
    logic [8:0]  dataIn;
    logic [31:0] drawIndex;
    logic        drawEn;

    int compared = 0, mismatched = 0;

    typedef struct {
        logic [31:0] idx;
        logic [8:0]  pix;
    } exp_t;
    exp_t sb[$];

    int          mpx, mpy;
    bit          mdxn, mdyn;
    logic [31:0] mask;
    int          cyc, first_en, last_en, loaded_at, nwrites, nloaded;
    logic [31:0] m;
    bit          ab;
    int          cnt;

    rect_raster_renderer #(
        .FB_W(W), .FB_H(H), .RECT_W(RW), .RECT_H(RH), .BG_COLOR(9'h000)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .SW(SW),
        .loaded(loaded), .dataIn(dataIn), .drawIndex(drawIndex), .drawEn(drawEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        check("en_and_loaded", {31'd0, drawEn & loaded}, 32'd0);
        if (loaded === 1'b1) begin
            nloaded++;
            loaded_at = cyc;
        end
        if (drawEn === 1'b1) begin
            nwrites++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (dataIn != 9'h000) mask[drawIndex[4:0]] = 1'b1;
            if (sb.size() == 0) check("unexpected_draw", drawIndex, 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                check("draw_idx", drawIndex, e.idx);
                check("draw_pix", {23'd0, dataIn}, {23'd0, e.pix});
            end
        end
    endtask

    function automatic void push_frame();
        exp_t e;
        int x, y;
        for (int i = 0; i < N; i++) begin
            x = i % W;
            y = i / W;
            e.idx = 32'(i);
            e.pix = (x >= mpx && x < mpx + RW && y >= mpy && y < mpy + RH) ? SW[8:0] : 9'h000;
            sb.push_back(e);
        end
    endfunction

    function automatic void model_advance();
        if (SW[9]) return;
        if (!mdxn && mpx + RW == W) begin mdxn = 1; mpx--; end
        else if (mdxn && mpx == 0)  begin mdxn = 0; mpx++; end
        else                        mpx += mdxn ? -1 : 1;
        if (!mdyn && mpy + RH == H) begin mdyn = 1; mpy--; end
        else if (mdyn && mpy == 0)  begin mdyn = 0; mpy++; end
        else                        mpy += mdyn ? -1 : 1;
    endfunction

    task automatic run_frame(input int stall_at, input int abort_at,
                             output logic [31:0] mo, output bit aborted);
        sb.delete();
        push_frame();
        mask = '0; nwrites = 0; nloaded = 0;
        first_en = -1; last_en = -1; loaded_at = -1; aborted = 0;
        cyc = 0;
        ready = 1'b1;
        while (nloaded == 0 && cyc < 200 && !aborted) begin
            tick();
            if (drawEn === 1'b1 && drawIndex == 32'(stall_at)) begin
                ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("stall_no_en", {31'd0, drawEn}, 32'd0);
                    check("stall_idx_hold", drawIndex, 32'(stall_at));
                end
                ready = 1'b1;
            end
            if (drawEn === 1'b1 && drawIndex == 32'(abort_at)) begin
                #2 reset = 1'b0;
                #1;
                check("async_rst_loaded", {31'd0, loaded}, 32'd0);
                check("async_rst_en", {31'd0, drawEn}, 32'd0);
                check("async_rst_data", {23'd0, dataIn}, 32'd0);
                check("async_rst_idx", drawIndex, 32'd0);
                aborted = 1;
            end
        end
        mo = mask;
        if (!aborted) begin
            check("loaded_seen", 32'(nloaded), 32'd1);
            check("frame_writes", 32'(nwrites), 32'(N));
            check("first_en_latency", 32'(first_en), 32'd2);
            check("loaded_after_last", 32'(loaded_at), 32'(last_en + 1));
            check("sb_empty", 32'(sb.size()), 32'd0);
            tick();
            check("loaded_one_cycle", {31'd0, loaded}, 32'd0);
            model_advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        mpx = 0; mpy = 0; mdxn = 0; mdyn = 0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_loaded", {31'd0, loaded}, 32'd0);
        check("rst_en", {31'd0, drawEn}, 32'd0);
        check("rst_data", {23'd0, dataIn}, 32'd0);
        check("rst_idx", drawIndex, 32'd0);
        reset = 1'b1;

        // Frame 0: full colour, rectangle at origin
        SW = 10'h1FF;
        run_frame(-1, -1, m, ab);
        check("f0_mask", m, 32'h0000_0303);

        // Frame 1: 5-cycle stall after index 10
        ready = 1'b0; tick();
        SW = 10'h0A5;
        run_frame(10, -1, m, ab);
        check("f1_mask", m, 32'h0006_0600);

        // Frames 2..8: bounce sequence
        for (int f = 2; f < 9; f++) begin
            ready = 1'b0; tick();
            SW = {1'b0, 9'(9'h040 + f)};
            run_frame(-1, -1, m, ab);
            if (f == 6) check("f6_mask", m, 32'hC0C0_0000);
            if (f == 8) check("f8_mask", m, 32'h0000_3030);
        end

        // Reset mid-frame at index 20
        ready = 1'b0; tick();
        SW = 10'h111;
        run_frame(-1, 20, m, ab);
        check("abort_taken", {31'd0, ab}, 32'd1);
        ready = 1'b0;
        repeat (3) begin
            tick();
            check("abort_no_loaded", {31'd0, loaded}, 32'd0);
            check("abort_no_en", {31'd0, drawEn}, 32'd0);
        end
        reset = 1'b1;
        mpx = 0; mpy = 0; mdxn = 0; mdyn = 0;

        // Frozen animation across 3 frames
        SW = 10'h3C3;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin ready = 1'b0; tick(); end
            run_frame(-1, -1, m, ab);
            check("frozen_mask", m, 32'h0000_0303);
        end
        SW = 10'h0FF;
        ready = 1'b0; tick();
        run_frame(-1, -1, m, ab);
        check("unfrozen_first_mask", m, 32'h0000_0303);
        ready = 1'b0; tick();
        run_frame(-1, -1, m, ab);
        check("unfrozen_step_mask", m, 32'h0006_0600);

        // ready held high after loaded: no new frame
        cnt = 0;
        repeat (50) begin
            tick();
            if (drawEn === 1'b1) cnt++;
        end
        check("hold_ready_no_en", 32'(cnt), 32'd0);
        ready = 1'b0; tick();
        run_frame(-1, -1, m, ab);
        check("restart_mask", m, 32'h0C0C_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
